// File: rtl/sig_pattern_gen_pkg.sv
// rtl/sig_pattern_gen_pkg.sv - shared types, constants and pattern helper for sig_pattern_gen
package sig_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RANDOM   = 2'd0,
        MODE_ALL_ONE  = 2'd1,
        MODE_ALL_ZERO = 2'd2,
        MODE_TOGGLE   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam int TAP_0 = 0;
    localparam int TAP_1 = 2;
    localparam int TAP_2 = 3;
    localparam int TAP_3 = 5;

    function automatic logic pattern_bit(input mode_e mode, input logic rnd_bit, input logic tog_bit);
        case (mode)
            MODE_RANDOM:   return rnd_bit;
            MODE_ALL_ONE:  return 1'b1;
            MODE_ALL_ZERO: return 1'b0;
            default:       return tog_bit;
        endcase
    endfunction

endpackage

// File: rtl/sig_pattern_gen_lfsr16.sv
// rtl/sig_pattern_gen_lfsr16.sv - 16-bit Fibonacci LFSR with load and shift enables
module lfsr16
    import sig_pattern_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        shift_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        feedback;

    assign feedback = state_q[TAP_0] ^ state_q[TAP_1] ^ state_q[TAP_2] ^ state_q[TAP_3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LFSR_DEFAULT_SEED;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (shift_i) begin
            state_q <= {feedback, state_q[15:1]};
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/sig_pattern_gen.sv
// rtl/sig_pattern_gen.sv - burst bit-pattern generator (random/ones/zeros/toggle) with ones counter
module sig_pattern_gen
    import sig_pattern_gen_pkg::*;
#(
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic              a_o,
    output logic              a_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  ones_count_o
);

    state_e             state_q;
    mode_e              mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   ones_q;
    logic               a_q;
    logic               a_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               tog_q;

    logic               start_ok_d;
    logic               shift_d;
    logic [LFSR_W-1:0]  seed_d;
    logic [15:0]        lfsr_state;
    logic               lfsr_unused;

    assign start_ok_d = (state_q == ST_IDLE) && start_i && !abort_i;
    assign shift_d    = (state_q == ST_RUN);
    assign seed_d     = (seed_i == '0) ? LFSR_DEFAULT_SEED : seed_i;

    lfsr16 u_lfsr (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .load_i  (start_ok_d),
        .seed_i  (seed_d),
        .shift_i (shift_d),
        .state_o (lfsr_state)
    );

    // Only the two low bits feed the output: bit 1 becomes bit 0 after this cycle's shift.
    assign lfsr_unused = ^lfsr_state[15:2];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_RANDOM;
            cnt_q     <= '0;
            ones_q    <= '0;
            a_q       <= 1'b0;
            a_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tog_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok_d) begin
                        mode_q <= mode_e'(mode_i);
                        cnt_q  <= len_i;
                        ones_q <= '0;
                        busy_q <= 1'b1;
                        tog_q  <= 1'b0;
                        if (len_i == '0) begin
                            state_q   <= ST_FINISH;
                            a_q       <= 1'b0;
                            a_valid_q <= 1'b0;
                        end else begin
                            state_q   <= ST_RUN;
                            a_q       <= pattern_bit(mode_e'(mode_i), seed_d[0], 1'b1);
                            a_valid_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    ones_q <= ones_q + {{(CNT_W-1){1'b0}}, a_q};
                    if (abort_i) begin
                        state_q   <= ST_IDLE;
                        a_q       <= 1'b0;
                        a_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q   <= ST_FINISH;
                        a_q       <= 1'b0;
                        a_valid_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        a_q   <= pattern_bit(mode_q, lfsr_state[1], tog_q);
                        tog_q <= ~tog_q;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    a_q       <= 1'b0;
                    a_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign a_o          = a_q;
    assign a_valid_o    = a_valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ones_count_o = ones_q;

endmodule

// File: tb/tb_sig_pattern_gen.sv
// tb/tb_sig_pattern_gen.sv - scoreboard bench for sig_pattern_gen
module tb_sig_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  len;
    logic [15:0] seed;
    logic        a;
    logic        a_valid;
    logic        busy;
    logic        done;
    logic [7:0]  ones;

    int n_checks = 0;
    int n_fail   = 0;
    logic sb[$];

    sig_pattern_gen #(.LFSR_W(16), .CNT_W(8)) dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (start),
        .abort_i      (abort),
        .mode_i       (mode),
        .len_i        (len),
        .seed_i       (seed),
        .a_o          (a),
        .a_valid_o    (a_valid),
        .busy_o       (busy),
        .done_o       (done),
        .ones_count_o (ones)
    );

    always #5 clk = ~clk;

    task automatic push_model(input logic [1:0] m, input int n, input logic [15:0] s, output int n_ones);
        logic [15:0] l;
        logic        b;
        logic        t;
        l = (s == 16'h0) ? 16'hACE1 : s;
        t = 1'b1;
        n_ones = 0;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0:    b = l[0];
                2'd1:    b = 1'b1;
                2'd2:    b = 1'b0;
                default: b = t;
            endcase
            sb.push_back(b);
            n_ones += int'(b);
            t = ~t;
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end
    endtask

    // Starts a burst and monitors it cycle by cycle; cycle 1 is the cycle after the start cycle.
    task automatic run_burst(input logic [1:0] m, input logic [7:0] l, input logic [15:0] s,
                             input int abort_at, input int restart_at,
                             output int done_cyc, output int n_valid);
        int   cyc;
        logic exp_bit;
        logic exp_busy;
        @(negedge clk);
        start = 1'b1; mode = m; len = l; seed = s;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = -1; n_valid = 0;
        while (cyc < 40) begin
            start = 1'b0;
            abort = 1'b0;
            if (a_valid) begin
                n_valid++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow cyc=%0d got a_valid=1 required no more bits", cyc);
                end else begin
                    exp_bit = sb.pop_front();
                    if (a !== exp_bit) begin
                        n_fail++;
                        $display("FAIL bit cyc=%0d got a=%b required %b", cyc, a, exp_bit);
                    end
                end
            end else begin
                n_checks++;
                if (a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL a_when_invalid cyc=%0d got a=%b required 0", cyc, a);
                end
            end
            exp_busy = (abort_at > 0) ? (cyc <= abort_at) : (cyc <= int'(l) + 1);
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got %b required %b", cyc, busy, exp_busy);
            end
            if (done === 1'b1) begin
                if (done_cyc != -1) begin
                    n_fail++;
                    $display("FAIL done_twice cyc=%0d got second pulse required one", cyc);
                end
                done_cyc = cyc;
            end
            if (cyc == abort_at) abort = 1'b1;
            if (cyc == restart_at) begin
                start = 1'b1; mode = 2'd2; len = 8'd1;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d bits unconsumed required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; len = 8'd0; seed = 16'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a, a_valid, busy, done, ones} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_state got a=%b v=%b busy=%b done=%b ones=%0d required all 0",
                     a, a_valid, busy, done, ones);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_one();
        int dc, nv;
        for (int i = 0; i < 5; i++) sb.push_back(1'b1);
        run_burst(2'd1, 8'd5, 16'h1234, 0, 0, dc, nv);
        n_checks++;
        if (dc != 7) begin n_fail++; $display("FAIL all_one_done_cycle got %0d required 7", dc); end
        n_checks++;
        if (nv != 5) begin n_fail++; $display("FAIL all_one_valid_count got %0d required 5", nv); end
        n_checks++;
        if (ones !== 8'd5) begin n_fail++; $display("FAIL all_one_ones got %0d required 5", ones); end
        repeat (4) @(negedge clk);
        n_checks++;
        if (ones !== 8'd5) begin n_fail++; $display("FAIL ones_hold_idle got %0d required 5", ones); end
    endtask

    task automatic test_toggle();
        int dc, nv;
        sb.push_back(1'b1); sb.push_back(1'b0); sb.push_back(1'b1); sb.push_back(1'b0);
        run_burst(2'd3, 8'd4, 16'h0, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'd2) begin n_fail++; $display("FAIL toggle_ones got %0d required 2", ones); end
        n_checks++;
        if (dc != 6) begin n_fail++; $display("FAIL toggle_done_cycle got %0d required 6", dc); end
    endtask

    task automatic test_random_seed1();
        int dc, nv;
        sb.push_back(1'b1); sb.push_back(1'b0); sb.push_back(1'b0);
        run_burst(2'd0, 8'd3, 16'h0001, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'd1) begin n_fail++; $display("FAIL seed1_ones got %0d required 1", ones); end
    endtask

    task automatic test_random_seed0();
        int dc, nv, exp_ones;
        sb.push_back(1'b1);
        run_burst(2'd0, 8'd1, 16'h0000, 0, 0, dc, nv);
        push_model(2'd0, 12, 16'h0000, exp_ones);
        run_burst(2'd0, 8'd12, 16'h0000, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'(exp_ones)) begin
            n_fail++; $display("FAIL seed0_ones got %0d required %0d", ones, exp_ones);
        end
    endtask

    task automatic test_random_long();
        int dc, nv, exp_ones;
        logic [15:0] s;
        for (int k = 0; k < 3; k++) begin
            s = 16'($urandom_range(1, 65535));
            push_model(2'd0, 20, s, exp_ones);
            run_burst(2'd0, 8'd20, s, 0, 0, dc, nv);
            n_checks++;
            if (ones !== 8'(exp_ones)) begin
                n_fail++; $display("FAIL random_ones seed=%h got %0d required %0d", s, ones, exp_ones);
            end
            n_checks++;
            if (dc != 22) begin n_fail++; $display("FAIL random_done_cycle got %0d required 22", dc); end
        end
    endtask

    task automatic test_all_zero_and_len_zero();
        int dc, nv;
        for (int i = 0; i < 6; i++) sb.push_back(1'b0);
        run_burst(2'd2, 8'd6, 16'h0, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'd0) begin n_fail++; $display("FAIL all_zero_ones got %0d required 0", ones); end
        for (int i = 0; i < 3; i++) sb.push_back(1'b1);
        run_burst(2'd1, 8'd3, 16'h0, 0, 0, dc, nv);
        run_burst(2'd1, 8'd0, 16'h0, 0, 0, dc, nv);
        n_checks++;
        if (nv != 0) begin n_fail++; $display("FAIL len0_valid got %0d required 0", nv); end
        n_checks++;
        if (dc != 2) begin n_fail++; $display("FAIL len0_done_cycle got %0d required 2", dc); end
        n_checks++;
        if (ones !== 8'd0) begin n_fail++; $display("FAIL len0_ones_cleared got %0d required 0", ones); end
    endtask

    task automatic test_start_in_run();
        int dc, nv;
        for (int i = 0; i < 6; i++) sb.push_back(1'b1);
        run_burst(2'd1, 8'd6, 16'h0, 0, 2, dc, nv);
        n_checks++;
        if (dc != 8) begin n_fail++; $display("FAIL restart_done_cycle got %0d required 8", dc); end
        n_checks++;
        if (ones !== 8'd6) begin n_fail++; $display("FAIL restart_ones got %0d required 6", ones); end
    endtask

    task automatic test_abort();
        int dc, nv;
        for (int i = 0; i < 3; i++) sb.push_back(1'b1);
        run_burst(2'd1, 8'd8, 16'h0, 3, 0, dc, nv);
        n_checks++;
        if (dc != -1) begin n_fail++; $display("FAIL abort_no_done got pulse at %0d required none", dc); end
        n_checks++;
        if (ones !== 8'd3) begin n_fail++; $display("FAIL abort_ones got %0d required 3", ones); end
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mode = 2'd1; len = 8'd4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy, a_valid, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_beats_start cyc=%0d got busy=%b v=%b done=%b required 0", i, busy, a_valid, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; mode = 2'd1; len = 8'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        n_checks++;
        if ({a, a_valid, busy, done, ones} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid got a=%b v=%b busy=%b done=%b ones=%0d required all 0",
                     a, a_valid, busy, done, ones);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({done, busy, a_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_quiet cyc=%0d got done=%b busy=%b v=%b required 0", i, done, busy, a_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc, nv, exp_ones;
        push_model(2'd3, 7, 16'h0, exp_ones);
        run_burst(2'd3, 8'd7, 16'h0, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'(exp_ones)) begin n_fail++; $display("FAIL b2b_first_ones got %0d required %0d", ones, exp_ones); end
        push_model(2'd0, 9, 16'hBEEF, exp_ones);
        run_burst(2'd0, 8'd9, 16'hBEEF, 0, 0, dc, nv);
        n_checks++;
        if (ones !== 8'(exp_ones)) begin n_fail++; $display("FAIL b2b_second_ones got %0d required %0d", ones, exp_ones); end
    endtask

    initial begin
        test_reset();
        test_all_one();
        test_toggle();
        test_random_seed1();
        test_random_seed0();
        test_random_long();
        test_all_zero_and_len_zero();
        test_start_in_run();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
